ps2_key_tracker: RTL
====================

Name: ps2_key_tracker

Overview:
Upstream stage of the RGB/animation controller. It consumes the byte stream from the PS/2 serial receiver (scan code set 2), decodes make/break/E0/E1 framing, and keeps two 128-bit level bitmaps of currently held keys: keys[code] for plain codes and e_keys[code] for E0-prefixed codes. The controller reads these bitmaps directly as held-key flags. A one-cycle event strobe reports each completed make or break.

Parameters:
TIMEOUT_CYCLES, 2500000, idle cycles after a prefix byte before the partial sequence is abandoned (50 ms at 50 MHz); must be >= 2
PAUSE_SKIP, 7, bytes swallowed after E1 (rest of the Pause sequence)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
ps2_byte  input  8  received byte from the PS/2 receiver
ps2_byte_valid  input  1  one-cycle strobe; ps2_byte is valid this cycle
clear  input  1  synchronous release-all (e.g. receiver parity/framing error)
keys  output  128  held map, non-extended codes; bit n = code n held
e_keys  output  128  held map, E0-prefixed codes
event_valid  output  1  one-cycle pulse per completed make/break
event_code  output  7  code of the completed event
event_ext  output  1  event was E0-prefixed
event_break  output  1  1 = break (release), 0 = make (press)
pause_pulse  output  1  one-cycle pulse when an E1 sequence starts
seq_error  output  1  sticky; set on timeout or an illegal byte inside a sequence; cleared by reset or clear

Behaviour:
- Reset (reset=0, asynchronous): keys=0, e_keys=0, event_valid=0, event_code=0, event_ext=0, event_break=0, pause_pulse=0, seq_error=0. FSM goes to IDLE, timeout counter=0, skip counter=0.
- The FSM advances only on cycles where ps2_byte_valid=1. States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> SKIP; skip counter=PAUSE_SKIP; pause_pulse=1 next cycle.
  - Byte 00-7F: keys[b]<=1; make event.
  - Other 80-FF (AA, FA, EE, FE, 83, ...): ignored; no event; no error.
- EXT:
  - F0 -> EXT_BRK.
  - Byte 00-7F: e_keys[b]<=1; make event, ext=1; -> IDLE.
  - Anything else: seq_error<=1; -> IDLE.
- BRK:
  - Byte 00-7F: keys[b]<=0; break event; -> IDLE.
  - Other byte: seq_error<=1; -> IDLE.
- EXT_BRK:
  - Byte 00-7F: e_keys[b]<=0; break event, ext=1; -> IDLE.
  - Other byte: seq_error<=1; -> IDLE.
- SKIP: each valid byte decrements the skip counter; when it reaches 0 -> IDLE. No map change and no event.
- Latency: the map bit and event outputs update on the clk edge that samples the final byte's valid, and are visible the following cycle.
  - event_valid is high for exactly that one cycle.
  - event_code, event_ext and event_break hold their last values until the next event.
- Make of a bit that is already 1 (typematic repeat): the map is unchanged, but the event still fires. Break of a bit that is already 0: no map change; event fires.
- Timeout: the counter resets on every valid byte and counts while in EXT, BRK, EXT_BRK or SKIP with no byte. On reaching TIMEOUT_CYCLES-1: -> IDLE, seq_error<=1, no map change. In IDLE the counter is held at 0.
- clear=1: keys=0, e_keys=0, seq_error=0, FSM -> IDLE, counters=0.
  - Any byte presented in the same cycle is discarded, and no event fires.
  - clear has priority over everything except reset.
- Reset released mid-sequence: decoding restarts in IDLE. Orphan trailing bytes are then decoded as fresh codes; this is accepted behaviour.
- The keys and e_keys maps are independent: keys[0x14] and e_keys[0x14] may both be 1.

Test Plan:
- Reset, then stream 1C, F0 1C -> keys[28] reads 1 after the first byte and 0 after the break. Two event_valid pulses: (28, ext=0, brk=0) then (28, ext=0, brk=1).
- Stream E0 75, then 75 -> e_keys[117]=1 and keys[117]=1. Then E0 F0 75 -> e_keys[117]=0 while keys[117] stays 1.
- Stream E1 14 77 E1 F0 14 F0 77 -> one pause_pulse, zero event_valid, keys and e_keys unchanged, FSM back in IDLE. A following 29 then sets keys[41].
- Send F0, then no byte for TIMEOUT_CYCLES (TIMEOUT_CYCLES=16 in the bench) -> seq_error=1, state IDLE. A subsequent 1C sets keys[28] and is not treated as a break.
- Hold 16 and 1E, then assert clear together with byte F0 -> both bits 0, seq_error 0, no event. The next 16 sets keys[22].
- Drop reset to 0 asynchronously between clk edges while keys[90]=1 -> keys reads 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code set 2 decoder: tracks held keys as plain and E0-prefixed
// bitmaps, strobes one event per completed make/break, and swallows Pause.
module ps2_key_tracker #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned PAUSE_SKIP     = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   ps2_byte,
  input  logic         ps2_byte_valid,
  input  logic         clear,
  output logic [127:0] keys,
  output logic [127:0] e_keys,
  output logic         event_valid,
  output logic [6:0]   event_code,
  output logic         event_ext,
  output logic         event_break,
  output logic         pause_pulse,
  output logic         seq_error
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SW = $clog2(PAUSE_SKIP + 1);

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_F0 = 8'hF0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_e;

  state_e         state_q;
  logic [TW-1:0]  tmo_q;
  logic [SW-1:0]  skip_q;
  logic [127:0]   keys_q;
  logic [127:0]   e_keys_q;
  logic           event_valid_q;
  logic [6:0]     event_code_q;
  logic           event_ext_q;
  logic           event_break_q;
  logic           pause_pulse_q;
  logic           seq_error_q;

  logic           is_code;
  assign is_code = ~ps2_byte[7];

  // Single-process decoder; strobes default low every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      tmo_q         <= '0;
      skip_q        <= '0;
      keys_q        <= '0;
      e_keys_q      <= '0;
      event_valid_q <= 1'b0;
      event_code_q  <= '0;
      event_ext_q   <= 1'b0;
      event_break_q <= 1'b0;
      pause_pulse_q <= 1'b0;
      seq_error_q   <= 1'b0;
    end else begin
      event_valid_q <= 1'b0;
      pause_pulse_q <= 1'b0;
      if (clear) begin
        state_q     <= S_IDLE;
        tmo_q       <= '0;
        skip_q      <= '0;
        keys_q      <= '0;
        e_keys_q    <= '0;
        seq_error_q <= 1'b0;
      end else if (ps2_byte_valid) begin
        tmo_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (ps2_byte == BYTE_E0) begin
              state_q <= S_EXT;
            end else if (ps2_byte == BYTE_F0) begin
              state_q <= S_BRK;
            end else if (ps2_byte == BYTE_E1) begin
              state_q       <= S_SKIP;
              skip_q        <= SW'(PAUSE_SKIP);
              pause_pulse_q <= 1'b1;
            end else if (is_code) begin
              keys_q[ps2_byte[6:0]] <= 1'b1;
              event_valid_q         <= 1'b1;
              event_code_q          <= ps2_byte[6:0];
              event_ext_q           <= 1'b0;
              event_break_q         <= 1'b0;
            end
          end
          S_EXT: begin
            if (ps2_byte == BYTE_F0) begin
              state_q <= S_EXT_BRK;
            end else begin
              state_q <= S_IDLE;
              if (is_code) begin
                e_keys_q[ps2_byte[6:0]] <= 1'b1;
                event_valid_q           <= 1'b1;
                event_code_q            <= ps2_byte[6:0];
                event_ext_q             <= 1'b1;
                event_break_q           <= 1'b0;
              end else begin
                seq_error_q <= 1'b1;
              end
            end
          end
          S_BRK, S_EXT_BRK: begin
            state_q <= S_IDLE;
            if (is_code) begin
              if (state_q == S_EXT_BRK) begin
                e_keys_q[ps2_byte[6:0]] <= 1'b0;
              end else begin
                keys_q[ps2_byte[6:0]] <= 1'b0;
              end
              event_valid_q <= 1'b1;
              event_code_q  <= ps2_byte[6:0];
              event_ext_q   <= (state_q == S_EXT_BRK);
              event_break_q <= 1'b1;
            end else begin
              seq_error_q <= 1'b1;
            end
          end
          S_SKIP: begin
            if (skip_q <= SW'(1)) begin
              state_q <= S_IDLE;
              skip_q  <= '0;
            end else begin
              skip_q <= skip_q - SW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        // Abandon a partial sequence after a long silence.
        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_q     <= S_IDLE;
          tmo_q       <= '0;
          skip_q      <= '0;
          seq_error_q <= 1'b1;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end
    end
  end

  assign keys        = keys_q;
  assign e_keys      = e_keys_q;
  assign event_valid = event_valid_q;
  assign event_code  = event_code_q;
  assign event_ext   = event_ext_q;
  assign event_break = event_break_q;
  assign pause_pulse = pause_pulse_q;
  assign seq_error   = seq_error_q;

endmodule
